// File: rtl/alu_rr_sched.sv
// alu_rr_sched: one 4-bit ALU shared by two requesters.
//
// Arbitration is round-robin, and the valid/ready handshakes are the only flow control.
// An accepted operation is evaluated combinationally in its grant cycle. Its result and
// flags are captured in a one-deep response register, tagged with the requester id.
// Each port also has a saturating grant counter for observability.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reqN_valid/ready      request handshake for port N (N = 0, 1)
//   reqN_a, reqN_b        4-bit operands for port N
//   reqN_op               3-bit opcode for port N
//   rsp_valid/ready       response handshake
//   rsp_id                requester that issued the held response
//   rsp_result            4-bit ALU result
//   rsp_zero/carry/of     zero, carry/borrow and signed-overflow flags
//   gnt_cnt0, gnt_cnt1    saturating per-port grant counters
module alu_rr_sched #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [3:0]       rsp_result,
   output logic             rsp_zero,
   output logic             rsp_carry,
   output logic             rsp_of,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic             valid_q;
   logic             id_q;
   logic [3:0]       result_q;
   logic             zero_q;
   logic             carry_q;
   logic             of_q;
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt1_q;
   logic             ptr_q;  // port favoured when both request

   logic       can_accept;
   logic       gnt0;
   logic       gnt1;
   logic [3:0] sel_a;
   logic [3:0] sel_b;
   logic [2:0] sel_op;
   logic [4:0] sum5;
   logic [4:0] diff5;
   logic [3:0] alu_r;
   logic       alu_z;
   logic       alu_c;
   logic       alu_v;

   // The held response can be replaced in the same cycle that it drains.
   assign can_accept = ~valid_q | rsp_ready;

   // A port is granted when it is the sole requester or when it holds priority.
   assign gnt0 = can_accept & req0_valid & (~req1_valid | ~ptr_q);
   assign gnt1 = can_accept & req1_valid & (~req0_valid | ptr_q);

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      sel_a  = gnt1 ? req1_a  : req0_a;
      sel_b  = gnt1 ? req1_b  : req0_b;
      sel_op = gnt1 ? req1_op : req0_op;
      sum5   = {1'b0, sel_a} + {1'b0, sel_b};
      diff5  = {1'b0, sel_a} - {1'b0, sel_b};
      alu_r  = 4'h0;
      alu_z  = 1'b0;
      alu_c  = 1'b0;
      alu_v  = 1'b0;
      case (sel_op)
         3'b000: begin
            alu_r = sum5[3:0];
            alu_c = sum5[4];
            alu_v = (sel_a[3] == sel_b[3]) & (alu_r[3] != sel_a[3]);
            alu_z = (alu_r == 4'h0);
         end
         3'b001: begin
            alu_r = diff5[3:0];
            alu_c = diff5[4];  // borrow out: set when a < b unsigned
            alu_v = (sel_a[3] != sel_b[3]) & (alu_r[3] != sel_a[3]);
            alu_z = (alu_r == 4'h0);
         end
         3'b010: alu_r = ~sel_a;
         3'b011: alu_r = sel_a & sel_b;
         3'b100: alu_r = sel_a | sel_b;
         3'b101: alu_r = sel_a ^ sel_b;
         3'b110: alu_r = {3'b000, ($signed(sel_a) < $signed(sel_b))};
         3'b111: alu_r = {3'b000, (sel_a == sel_b)};
         default: alu_r = 4'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         id_q     <= 1'b0;
         result_q <= 4'h0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         of_q     <= 1'b0;
         ptr_q    <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         if (gnt0 | gnt1) begin
            valid_q  <= 1'b1;
            id_q     <= gnt1;
            result_q <= alu_r;
            zero_q   <= alu_z;
            carry_q  <= alu_c;
            of_q     <= alu_v;
            ptr_q    <= gnt0;  // priority passes to the port that lost
         end else if (rsp_ready) begin
            valid_q <= 1'b0;
         end
         if (gnt0 && cnt0_q != CntMax) begin
            cnt0_q <= cnt0_q + CNT_W'(1);
         end
         if (gnt1 && cnt1_q != CntMax) begin
            cnt1_q <= cnt1_q + CNT_W'(1);
         end
      end
   end

   assign rsp_valid  = valid_q;
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign rsp_zero   = zero_q;
   assign rsp_carry  = carry_q;
   assign rsp_of     = of_q;
   assign gnt_cnt0   = cnt0_q;
   assign gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched.
//
// The driver issues requests on the falling edge and checks handshakes and counters
// against a behavioural model. Each grant pushes its expected response into a queue.
// A monitor compares the held response with the front of that queue and pops the
// entry when the response is consumed.
module tb_alu_rr_sched;

   localparam int unsigned CNT_W = 2;
   localparam int CMAX = 3;

   typedef struct packed {
      logic       id;
      logic [3:0] r;
      logic       z;
      logic       c;
      logic       v;
   } rsp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
   logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0] req0_op = '0, req1_op = '0;
   logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_of;
   logic [3:0] rsp_result;
   logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

   always #5 clk = ~clk;

   alu_rr_sched #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_carry  (rsp_carry),
      .rsp_of     (rsp_of),
      .gnt_cnt0   (gnt_cnt0),
      .gnt_cnt1   (gnt_cnt1)
   );

   rsp_t q[$];
   int n_checks = 0;
   int n_fail = 0;
   // Model state: response held, favoured port, grant counts.
   int m_valid = 0;
   int m_fav = 0;
   int m_cnt0 = 0;
   int m_cnt1 = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rsp_t ref_alu(input logic id, input int a, input int b, input int op);
      rsp_t res;
      int sa, sb, full, r, s;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      res = '0;
      res.id = id;
      r = 0;
      case (op)
         0: begin
            full = a + b;
            r = full % 16;
            s = sa + sb;
            res.c = (full > 15);
            res.v = (s > 7) || (s < -8);
            res.z = (r == 0);
         end
         1: begin
            full = a - b;
            r = (full + 16) % 16;
            s = sa - sb;
            res.c = (a < b);
            res.v = (s > 7) || (s < -8);
            res.z = (r == 0);
         end
         2: r = 15 - a;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = (sa < sb) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      res.r = 4'(r);
      return res;
   endfunction

   // One clock of stimulus, followed by the handshake checks and the model update.
   task automatic cycle(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [2:0] o0, input logic v1, input logic [3:0] a1,
                        input logic [3:0] b1, input logic [2:0] o1, input logic rr,
                        output logic g0, output logic g1);
      bit can;
      @(negedge clk);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
      rsp_ready = rr;
      #1;
      can = (m_valid == 0) || rr;
      g0 = 1'b0;
      g1 = 1'b0;
      if (can) begin
         if (v0 && v1) begin
            if (m_fav == 0) g0 = 1'b1;
            else g1 = 1'b1;
         end else if (v0) begin
            g0 = 1'b1;
         end else if (v1) begin
            g1 = 1'b1;
         end
      end
      chk("req0_ready", int'(req0_ready), int'(g0));
      chk("req1_ready", int'(req1_ready), int'(g1));
      chk("rsp_valid", int'(rsp_valid), m_valid);
      chk("gnt_cnt0", int'(gnt_cnt0), m_cnt0);
      chk("gnt_cnt1", int'(gnt_cnt1), m_cnt1);
      if (g0 || g1) begin
         q.push_back(g1 ? ref_alu(1'b1, a1, b1, o1) : ref_alu(1'b0, a0, b0, o0));
         m_valid = 1;
         m_fav = g0 ? 1 : 0;
         if (g0 && m_cnt0 < CMAX) m_cnt0++;
         if (g1 && m_cnt1 < CMAX) m_cnt1++;
      end else if (rr) begin
         m_valid = 0;
      end
   endtask

   // Reset is asserted and released between clock edges. The check made while reset
   // is held shows that the clear is asynchronous.
   task automatic do_reset();
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_result", int'(rsp_result), 0);
      chk("rst_flags", int'({rsp_zero, rsp_carry, rsp_of}), 0);
      chk("rst_gnt_cnt0", int'(gnt_cnt0), 0);
      chk("rst_gnt_cnt1", int'(gnt_cnt1), 0);
      q.delete();
      m_valid = 0; m_fav = 0; m_cnt0 = 0; m_cnt1 = 0;
      @(negedge clk);
      #3 rst_n = 1'b1;
   endtask

   // Monitor: compares the held response each cycle and pops it once it is consumed.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && rsp_valid) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected: got id=%0d r=%0h with nothing expected",
                        rsp_id, rsp_result);
            end else begin
               e = q[0];
               if ({rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_of} != e) begin
                  n_fail++;
                  $display("FAIL rsp: got id=%0d r=%0h z=%0d c=%0d v=%0d expected id=%0d r=%0h z=%0d c=%0d v=%0d",
                           rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_of,
                           e.id, e.r, e.z, e.c, e.v);
               end
               if (rsp_ready) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      logic g0, g1;
      logic pv0, pv1;
      logic [3:0] pa0, pb0, pa1, pb1;
      logic [2:0] po0, po1;
      int sat_exp[5] = '{1, 2, 3, 3, 3};

      do_reset();

      // Counter saturation: five back-to-back port 0 grants.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 4'h1, 4'h1, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
         @(posedge clk);
         #1;
         chk("sat_cnt0", int'(gnt_cnt0), sat_exp[i]);
         chk("sat_cnt1", int'(gnt_cnt1), 0);
      end
      cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);

      do_reset();

      // First operation: 3 + 5.
      cycle(1'b1, 4'h3, 4'h5, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      @(posedge clk);
      #1;
      chk("t1_result", int'(rsp_result), 8);
      chk("t1_of", int'(rsp_of), 1);

      // Both ports valid continuously: grants alternate.
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 4'h7, 4'h7, 3'b001, 1'b1, 4'h9, 4'h2, 3'b011, 1'b1, g0, g1);

      // Backpressure: hold the response while port 1 waits, then drain and grant together.
      cycle(1'b1, 4'h6, 4'h3, 3'b101, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b1, 4'hC, 4'h5, 3'b100, 1'b0, g0, g1);
      cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b1, 4'hC, 4'h5, 3'b100, 1'b1, g0, g1);

      // Signed compare and flag corner cases.
      cycle(1'b1, 4'hE, 4'h2, 3'b110, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b1, 4'h2, 4'h5, 3'b001, 1'b1, g0, g1);
      cycle(1'b1, 4'h8, 4'h1, 3'b001, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      cycle(1'b1, 4'hF, 4'h1, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b1, 4'h5, 4'h5, 3'b111, 1'b1, g0, g1);
      cycle(1'b1, 4'hA, 4'h0, 3'b010, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);

      // Random traffic: requests stay stable until they are accepted.
      pv0 = 1'b0; pv1 = 1'b0;
      pa0 = '0; pb0 = '0; po0 = '0; pa1 = '0; pb1 = '0; po1 = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pv0 && ($urandom % 3 != 0)) begin
            pv0 = 1'b1; pa0 = 4'($urandom); pb0 = 4'($urandom); po0 = 3'($urandom);
         end
         if (!pv1 && ($urandom % 3 != 0)) begin
            pv1 = 1'b1; pa1 = 4'($urandom); pb1 = 4'($urandom); po1 = 3'($urandom);
         end
         cycle(pv0, pa0, pb0, po0, pv1, pa1, pb1, po1, 1'($urandom % 4 != 0), g0, g1);
         if (g0) pv0 = 1'b0;
         if (g1) pv1 = 1'b0;
      end

      // Mid-stream reset while a response is held, then a both-valid restart.
      cycle(1'b1, 4'h2, 4'h3, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      chk("pre_reset_cnt0_nonzero", int'(gnt_cnt0 != 0), 1);
      do_reset();
      cycle(1'b1, 4'h1, 4'h2, 3'b011, 1'b1, 4'h4, 4'h4, 3'b111, 1'b1, g0, g1);
      chk("post_reset_first_gnt0", int'(req0_ready), 1);
      cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b1, 4'h4, 4'h4, 3'b111, 1'b1, g0, g1);

      // Drain everything and confirm every expected response was seen.
      cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      cycle(1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 4'h0, 4'h0, 3'b000, 1'b1, g0, g1);
      #3;
      chk("queue_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
